background_small_fetch: RTL and testbench
=========================================

BACKGROUND_SMALL_FETCH -- requirements
Module: background_small_fetch

Interface
REQ-001 Clk  in  1  single system/pixel clock; all state changes on its rising edge.
REQ-002 Reset_n  in  1  asynchronous, active-low reset.
REQ-003 DrawX  in  10  current screen column, 0..639.
REQ-004 DrawY  in  10  current screen row, 0..479.
REQ-005 blank  in  1  1 = active display region, 0 = blanking.
REQ-006 frame_start  in  1  one-cycle pulse at the start of each frame's vertical blank.
REQ-007 scroll_req  in  1  request to load a new horizontal scroll value.
REQ-008 scroll_x_in  in  9  requested scroll offset in background pixels.
REQ-009 scroll_ack  out  1  one-cycle pulse when a scroll request is captured.
REQ-010 rom_addr  out  17  address to the background index ROM.
REQ-011 rom_q  in  4  ROM data; synchronous, valid one cycle after rom_addr.
REQ-012 index_out  out  4  palette index to the downstream palette lookup.
REQ-013 index_valid  out  1  index_out carries an active-region pixel.
REQ-014 scroll_x  out  9  scroll offset in effect for the current frame.

Function
REQ-015 Background image SHALL be 512 x 240 indices, displayed 2x upscaled: bx = DrawX[9:1], by = DrawY[9:1].
REQ-016 rom_addr SHALL be by*512 + ((bx + scroll_x) mod 512), registered; mod is 9-bit truncation.
REQ-017 Latency SHALL be exactly 2 cycles from DrawX/DrawY/blank to index_out/index_valid: cycle 1 address register, cycle 2 output register.
REQ-018 blank SHALL be delayed 2 cycles in lockstep with the data path.
REQ-019 When the delayed blank = 0, index_out SHALL be 2 (black) and index_valid SHALL be 0.
REQ-020 When the delayed blank = 1, index_out SHALL equal rom_q and index_valid SHALL be 1.
REQ-021 Scroll control SHALL be an FSM with states S_IDLE and S_PENDING.
REQ-022 In S_IDLE, scroll_req = 1 SHALL capture scroll_x_in into a pending register, pulse scroll_ack and move to S_PENDING.
REQ-023 In S_PENDING, a further scroll_req SHALL overwrite the pending value and pulse scroll_ack (last request wins).
REQ-024 At frame_start in S_PENDING, scroll_x SHALL load the pending value and the FSM SHALL return to S_IDLE.
REQ-025 scroll_req and frame_start in the same cycle SHALL cause scroll_x to take scroll_x_in directly, pulse scroll_ack and leave the FSM in S_IDLE.
REQ-026 scroll_x SHALL NOT change outside a frame_start cycle (no mid-frame tearing).
REQ-027 DrawY >= 480 SHALL be treated as blanking regardless of blank; by SHALL saturate at 239 so rom_addr never exceeds 122879.

Reset
REQ-028 Reset_n low SHALL immediately force: FSM to S_IDLE, scroll_x = 0, pending = 0, rom_addr = 0, index_out = 2, index_valid = 0, scroll_ack = 0, blank delay line = 0.
REQ-029 Reset asserted mid-frame SHALL discard any pending scroll; the first valid output SHALL appear 2 cycles after the first active pixel following release.

Configuration
REQ-030 Macro BG_SCROLL_EN defined: REQ-021..REQ-026 behaviour as specified.
REQ-031 BG_SCROLL_EN undefined: FSM and pending register absent; scroll_x tied to 0; scroll_ack tied to 0; scroll_req and scroll_x_in ignored; data-path latency unchanged.

Structure
REQ-032 Package background_small_pkg SHALL hold BG_W=512, BG_H=240, BG_ADDR_W=17, BLACK_IDX=4'd2, FETCH_LAT=2 and the scroll-state enum.
REQ-033 Scroll FSM SHALL be the sub-module background_small_scroll_ctrl, instantiated only under BG_SCROLL_EN; the address/data pipeline stays in the top module.

Verification
REQ-034 Reset, DrawX=0, DrawY=0, blank=1, scroll 0 -> rom_addr=0 after 1 cycle; index_out = rom_q and index_valid=1 after 2 cycles.
REQ-035 scroll_req with scroll_x_in=100 mid-frame -> scroll_ack pulse; scroll_x stays 0 until frame_start, then 100; pixel DrawX=0, DrawY=2 -> rom_addr=612.
REQ-036 scroll_x=500, DrawX=40 (bx=20), DrawY=0 -> rom_addr=8 (wrap).
REQ-037 Requests 10 then 20 before frame_start -> two acks; scroll_x=20 after frame_start; simultaneous req 30 with frame_start -> scroll_x=30 that cycle.
REQ-038 blank=0 for a 1-cycle pixel -> index_out=2 and index_valid=0 exactly 2 cycles later, with neighbouring pixels unaffected.
REQ-039 Reset_n pulsed low while S_PENDING holds 55 -> after next frame_start scroll_x=0; without BG_SCROLL_EN any request -> scroll_x=0 and no ack.

Source files
------------

// File: rtl/background_small_fetch_pkg.sv
// Shared constants, scroll-state enum and address helper for the background fetch block.
// Ports: none (package only).
// Used by background_small_fetch and background_small_scroll_ctrl.
package background_small_pkg;

  localparam int BG_W      = 512;
  localparam int BG_H      = 240;
  localparam int BG_ADDR_W = 17;
  localparam int FETCH_LAT = 2;
  localparam int SCREEN_H  = 480;

  localparam logic [3:0] BLACK_IDX = 4'd2;
  localparam logic [7:0] BY_MAX    = 8'(BG_H - 1);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PENDING = 1'b1
  } scroll_state_t;

  // Row-major address into the 512-wide background; the column wraps at 512
  // because the 9-bit sum simply drops its carry.
  function automatic logic [BG_ADDR_W-1:0] bg_addr(input logic [7:0] by,
                                                   input logic [8:0] bx,
                                                   input logic [8:0] sx);
    logic [8:0] col;
    col = bx + sx;
    return {by, col};
  endfunction

endpackage

// File: rtl/background_small_scroll_ctrl.sv
// Horizontal scroll controller: buffers a requested scroll value and applies it only
// at frame_start so the image never tears mid-frame. Last request before a frame wins.
// Ports: clk/rst_n, frame_start, scroll_req, scroll_x_in -> scroll_ack (1-cycle pulse), scroll_x.
module background_small_scroll_ctrl
  import background_small_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       scroll_req,
  input  logic [8:0] scroll_x_in,
  output logic       scroll_ack,
  output logic [8:0] scroll_x
);

  scroll_state_t state, state_nxt;
  logic [8:0]    pending, pending_nxt;
  logic [8:0]    scroll_nxt;
  logic          ack_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pending    <= '0;
      scroll_x   <= '0;
      scroll_ack <= 1'b0;
    end else begin
      state      <= state_nxt;
      pending    <= pending_nxt;
      scroll_x   <= scroll_nxt;
      scroll_ack <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    scroll_nxt  = scroll_x;
    ack_nxt     = 1'b0;
    case (state)
      S_IDLE: begin
        if (scroll_req && frame_start) begin
          // Request lands exactly on the frame boundary: apply it directly.
          scroll_nxt = scroll_x_in;
          ack_nxt    = 1'b1;
        end else if (scroll_req) begin
          pending_nxt = scroll_x_in;
          ack_nxt     = 1'b1;
          state_nxt   = S_PENDING;
        end
      end
      S_PENDING: begin
        if (scroll_req && frame_start) begin
          // The fresh request supersedes the buffered one.
          scroll_nxt = scroll_x_in;
          ack_nxt    = 1'b1;
          state_nxt  = S_IDLE;
        end else if (frame_start) begin
          scroll_nxt = pending;
          state_nxt  = S_IDLE;
        end else if (scroll_req) begin
          pending_nxt = scroll_x_in;
          ack_nxt     = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: rtl/background_small_fetch.sv
// Background index fetch: maps the 640x480 raster onto a 2x-upscaled 512x240 index ROM
// with optional horizontal scroll (enabled by macro BG_SCROLL_EN; default build has none).
// Ports: Clk/Reset_n, DrawX/DrawY/blank raster in, frame_start, scroll_req/scroll_x_in ->
//   scroll_ack, rom_addr -> rom_q (sync ROM), index_out/index_valid after 2 cycles, scroll_x.
module background_small_fetch
  import background_small_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  input  logic                 blank,
  input  logic                 frame_start,
  input  logic                 scroll_req,
  input  logic [8:0]           scroll_x_in,
  output logic                 scroll_ack,
  output logic [BG_ADDR_W-1:0] rom_addr,
  input  logic [3:0]           rom_q,
  output logic [3:0]           index_out,
  output logic                 index_valid,
  output logic [8:0]           scroll_x
);

  logic [8:0] bx;
  logic [8:0] by_raw;
  logic [7:0] by;
  logic       active;
  logic       blank_d1, blank_d2;

`ifdef BG_SCROLL_EN
  background_small_scroll_ctrl u_scroll (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .frame_start(frame_start),
    .scroll_req (scroll_req),
    .scroll_x_in(scroll_x_in),
    .scroll_ack (scroll_ack),
    .scroll_x   (scroll_x)
  );
  logic unused_bits;
  assign unused_bits = DrawX[0];
`else
  assign scroll_x   = '0;
  assign scroll_ack = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{DrawX[0], frame_start, scroll_req, scroll_x_in};
`endif

  assign bx     = DrawX[9:1];
  assign by_raw = DrawY[9:1];
  // Rows past the visible area clamp to the last image row so the address
  // stays inside the ROM even while the raster runs through vertical blank.
  assign by     = (by_raw > {1'b0, BY_MAX}) ? BY_MAX : by_raw[7:0];
  assign active = blank && (DrawY < 10'(SCREEN_H));

  // Stage 1: address register. Stage 2 is the ROM's own output register,
  // so the blank flag is delayed twice to stay aligned with rom_q.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr <= '0;
      blank_d1 <= 1'b0;
      blank_d2 <= 1'b0;
    end else begin
      rom_addr <= bg_addr(by, bx, scroll_x);
      blank_d1 <= active;
      blank_d2 <= blank_d1;
    end
  end

  assign index_out   = blank_d2 ? rom_q : BLACK_IDX;
  assign index_valid = blank_d2;

endmodule

// File: tb/tb_background_small_fetch.sv
module tb_background_small_fetch;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        blank, frame_start, scroll_req;
  logic [8:0]  scroll_x_in;
  logic        scroll_ack;
  logic [16:0] rom_addr;
  logic [3:0]  rom_q = 4'd0;
  logic [3:0]  index_out;
  logic        index_valid;
  logic [8:0]  scroll_x;

  always #5 Clk = ~Clk;

  background_small_fetch dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .blank      (blank),
    .frame_start(frame_start),
    .scroll_req (scroll_req),
    .scroll_x_in(scroll_x_in),
    .scroll_ack (scroll_ack),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .index_out  (index_out),
    .index_valid(index_valid),
    .scroll_x   (scroll_x)
  );

`ifdef BG_SCROLL_EN
  localparam bit SCROLL_ON = 1'b1;
`else
  localparam bit SCROLL_ON = 1'b0;
`endif

  // Synthetic ROM contents: any address-dependent pattern will do.
  function automatic logic [3:0] rom_f(input int a);
    int v;
    v = (a ^ (a >> 5) ^ (a >> 11)) & 15;
    return v[3:0];
  endfunction

  always @(posedge Clk) rom_q <= rom_f(int'(rom_addr));

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: current scroll, an optional buffered scroll, and the
  // expected pipeline contents one and two edges downstream.
  int m_scroll, m_pend_val;
  bit m_pend;
  int e1_addr, e2_addr;
  bit e1_vis, e2_vis;
  bit exp_ack;

  task automatic model_reset();
    m_scroll = 0; m_pend_val = 0; m_pend = 0;
    e1_addr = 0; e2_addr = 0; e1_vis = 0; e2_vis = 0; exp_ack = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".addr"}, rom_addr, e1_addr);
    chk({tag, ".vld"}, index_valid, e2_vis);
    chk({tag, ".idx"}, index_out, e2_vis ? rom_f(e2_addr) : 2);
    chk({tag, ".ack"}, scroll_ack, exp_ack);
    chk({tag, ".sx"}, scroll_x, m_scroll);
  endtask

  // Called at a falling edge: drive one pixel, advance the model, wait one
  // clock and compare at the next falling edge.
  task automatic cycle(input string tag, input int dx, input int dy, input bit bl,
                       input bit fs, input bit req, input int sx);
    int bx, by;
    DrawX = 10'(dx); DrawY = 10'(dy); blank = bl;
    frame_start = fs; scroll_req = req; scroll_x_in = 9'(sx);
    bx = dx / 2;
    by = dy / 2;
    if (by > 239) by = 239;
    e2_addr = e1_addr; e2_vis = e1_vis;
    e1_addr = by * 512 + ((bx + m_scroll) % 512);
    e1_vis  = bl && (dy < 480);
    exp_ack = SCROLL_ON && req;
    if (SCROLL_ON) begin
      if (fs && req) begin
        m_scroll = sx; m_pend = 0;
      end else if (fs && m_pend) begin
        m_scroll = m_pend_val; m_pend = 0;
      end else if (req) begin
        m_pend_val = sx; m_pend = 1;
      end
    end
    @(posedge Clk);
    @(negedge Clk);
    check_outputs(tag);
  endtask

  task automatic do_reset();
    DrawX = '0; DrawY = '0; blank = 1'b0;
    frame_start = 1'b0; scroll_req = 1'b0; scroll_x_in = '0;
    Reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst.addr", rom_addr, 0);
    chk("rst.idx", index_out, 2);
    chk("rst.vld", index_valid, 0);
    chk("rst.ack", scroll_ack, 0);
    chk("rst.sx", scroll_x, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  initial begin
    Reset_n = 1'b1;
    DrawX = '0; DrawY = '0; blank = 1'b0;
    frame_start = 1'b0; scroll_req = 1'b0; scroll_x_in = '0;
    model_reset();
    @(negedge Clk);
    do_reset();

    // First pixel after reset, then its index one cycle later.
    cycle("first", 0, 0, 1, 0, 0, 0);
    cycle("first2", 2, 0, 1, 0, 0, 0);

    // Mid-frame request for 100, held until frame_start.
    cycle("req100", 10, 0, 1, 0, 1, 100);
    cycle("hold100", 0, 2, 1, 0, 0, 0);
    cycle("fs100", 0, 500, 0, 1, 0, 0);
    cycle("use100", 0, 2, 1, 0, 0, 0);

    // Wrap of the column sum at 512.
    cycle("req500", 0, 0, 0, 0, 1, 500);
    cycle("fs500", 0, 0, 0, 1, 0, 0);
    cycle("wrap", 40, 0, 1, 0, 0, 0);

    // Last request wins, then request coinciding with frame_start.
    cycle("req10", 0, 0, 1, 0, 1, 10);
    cycle("req20", 0, 0, 1, 0, 1, 20);
    cycle("fs20", 0, 490, 0, 1, 0, 0);
    cycle("fs30", 0, 490, 0, 1, 1, 30);
    cycle("after30", 6, 4, 1, 0, 0, 0);

    // Single blanked pixel between active neighbours.
    cycle("nb0", 100, 100, 1, 0, 0, 0);
    cycle("hole", 102, 100, 0, 0, 0, 0);
    cycle("nb1", 104, 100, 1, 0, 0, 0);
    cycle("nb2", 106, 100, 1, 0, 0, 0);
    cycle("nb3", 108, 100, 1, 0, 0, 0);

    // Rows beyond the screen: forced blank and clamped address.
    cycle("row480", 20, 480, 1, 0, 0, 0);
    cycle("row523", 638, 523, 1, 0, 0, 0);
    cycle("row479", 639, 479, 1, 0, 0, 0);
    cycle("tail", 0, 0, 0, 0, 0, 0);

    // Pending 55 dropped by reset.
    cycle("req55", 0, 0, 1, 0, 1, 55);
    do_reset();
    cycle("fs_after_rst", 0, 0, 0, 1, 0, 0);
    cycle("post_rst", 4, 0, 1, 0, 0, 0);
    cycle("post_rst2", 6, 0, 1, 0, 0, 0);

    // Randomized raster traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(599, 0) == 0) begin
        do_reset();
      end else begin
        cycle("rand",
              int'($urandom_range(639, 0)),
              int'($urandom_range(524, 0)),
              $urandom_range(7, 0) != 0,
              $urandom_range(29, 0) == 0,
              $urandom_range(7, 0) == 0,
              int'($urandom_range(511, 0)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
